// File: rtl/ddr4_rcd_ctrl_pkg.sv
// Shared types and constants for the DDR4 RCD mode-register sequencer:
// FSM states, power-up MR order, side-B inversion mask and the rank-1 CA mirror.
package ddr4_rcd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_CKE_WAIT,
    ST_MRS_CMD,
    ST_MRS_GAP,
    ST_IDLE,
    ST_REQ_CMD,
    ST_REQ_GAP
  } state_e;

  localparam logic [2:0] MR_ORDER [0:6] = '{3'd3, 3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0};

  localparam logic [17:0] SIDE_B_INV_MASK = 18'h22BF8;

  typedef struct packed {
    logic [17:0] da;
    logic [1:0]  dba;
    logic [1:0]  dbg;
  } ca_t;

  // Odd ranks are wired with these address/bank pins exchanged on the DIMM.
  function automatic ca_t mirror_ca(input ca_t c);
    ca_t m;
    m        = c;
    m.dba[0] = c.dba[1];
    m.dba[1] = c.dba[0];
    m.dbg[0] = c.dbg[1];
    m.dbg[1] = c.dbg[0];
    m.da[3]  = c.da[4];
    m.da[4]  = c.da[3];
    m.da[5]  = c.da[6];
    m.da[6]  = c.da[5];
    m.da[7]  = c.da[8];
    m.da[8]  = c.da[7];
    m.da[11] = c.da[13];
    m.da[13] = c.da[11];
    return m;
  endfunction

endpackage

// File: rtl/ddr4_rcd_mrs_sequencer_if.sv
// Runtime MRS request handshake plus the RCD-side command bus of the sequencer.
// The slave modport is the sequencer; the master modport is the requester/observer.
interface ddr4_rcd_mrs_sequencer_if;

  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_mr;
  logic        req_rank;
  logic [1:0]  req_side;
  logic [17:0] req_data;
  logic        init_done;

  logic        DRST_n;
  logic [1:0]  DCKE;
  logic        DCS0_n;
  logic        DCS1_n;
  logic        DACT_n;
  logic [17:0] DA;
  logic [1:0]  DBA;
  logic [1:0]  DBG;
  logic [1:0]  DODT;
  logic        DPAR;

  modport slave (
    input  req_valid, req_mr, req_rank, req_side, req_data,
    output req_ready, init_done,
    output DRST_n, DCKE, DCS0_n, DCS1_n, DACT_n, DA, DBA, DBG, DODT, DPAR
  );

  modport master (
    output req_valid, req_mr, req_rank, req_side, req_data,
    input  req_ready, init_done,
    input  DRST_n, DCKE, DCS0_n, DCS1_n, DACT_n, DA, DBA, DBG, DODT, DPAR
  );

endinterface

// File: rtl/ddr4_mrs_encode.sv
// Combinational MRS encoder: side-B inversion, rank-1 mirroring, chip select and parity.
// Parity is generated only when DDR4_RCD_CMD_PARITY_EN is defined, otherwise tied low.
module ddr4_mrs_encode
  import ddr4_rcd_ctrl_pkg::*;
#(
  parameter bit MIRROR_EN = 1'b0
) (
  input  logic [2:0]  i_mr,
  input  logic [17:0] i_val,
  input  logic        i_side_b,
  input  logic        i_rank,
  output logic        o_cs0_n,
  output logic        o_cs1_n,
  output logic [17:0] o_da,
  output logic [1:0]  o_dba,
  output logic [1:0]  o_dbg,
  output logic        o_par
);

  ca_t w_raw;
  ca_t w_ca;

  always_comb begin
    w_raw.da        = i_side_b ? (i_val ^ SIDE_B_INV_MASK) : i_val;
    w_raw.da[16:14] = 3'b000;
    w_raw.dba       = i_side_b ? ~i_mr[1:0] : i_mr[1:0];
    w_raw.dbg       = i_side_b ? {1'b1, ~i_mr[2]} : {1'b0, i_mr[2]};
    w_ca            = (MIRROR_EN && i_rank) ? mirror_ca(w_raw) : w_raw;
  end

  assign o_cs0_n = i_rank;
  assign o_cs1_n = ~i_rank;
  assign o_da    = w_ca.da;
  assign o_dba   = w_ca.dba;
  assign o_dbg   = w_ca.dbg;

`ifdef DDR4_RCD_CMD_PARITY_EN
  // Even parity over the command, DACT_n is always 1 for MRS.
  assign o_par = ^{1'b1, w_ca.da, w_ca.dba, w_ca.dbg};
`else
  assign o_par = 1'b0;
`endif

endmodule

// File: rtl/ddr4_rcd_mrs_sequencer.sv
// DDR4 RCD power-up and runtime MRS sequencer; all RCD command outputs are registered.
// Optional command parity: define DDR4_RCD_CMD_PARITY_EN (handled in ddr4_mrs_encode).
module ddr4_rcd_mrs_sequencer
  import ddr4_rcd_ctrl_pkg::*;
#(
  parameter int    NUM_RANKS    = 2,
  parameter int    T_RST_CYC    = 200,
  parameter int    T_CKE_CYC    = 500,
  parameter int    T_MRD        = 8,
  parameter int    T_MOD        = 24,
  parameter string MC_CA_MIRROR = "OFF"
) (
  input  logic                        CK_t,
  input  logic                        RST_n,
  input  logic [125:0]                MR_INIT,
  ddr4_rcd_mrs_sequencer_if.slave     bus
);

  localparam bit   MIRROR_EN = (MC_CA_MIRROR == "ON");
  localparam logic RANK_LAST = (NUM_RANKS > 1);
  localparam int   MAX_A     = (T_RST_CYC > T_CKE_CYC) ? T_RST_CYC : T_CKE_CYC;
  localparam int   MAX_B     = (T_MRD > T_MOD) ? T_MRD : T_MOD;
  localparam int   CNT_W     = $clog2(((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1);

  localparam logic [CNT_W-1:0] LD_RST = CNT_W'(T_RST_CYC);
  localparam logic [CNT_W-1:0] LD_CKE = CNT_W'(T_CKE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_MRD = CNT_W'(T_MRD - 1);
  localparam logic [CNT_W-1:0] LD_MOD = CNT_W'(T_MOD - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_mr_idx;
  logic             r_side;
  logic             r_rank;
  logic             r_last;
  logic [1:0]       r_sides;

  logic [2:0]       r_req_mr;
  logic             r_req_rank;
  logic [17:0]      r_req_data;

  logic             r_drst_n;
  logic [1:0]       r_dcke;
  logic             r_dcs0_n;
  logic             r_dcs1_n;
  logic [17:0]      r_da;
  logic [1:0]       r_dba;
  logic [1:0]       r_dbg;
  logic             r_dpar;
  logic             r_init_done;
  logic             r_req_ready;

  logic [17:0]      w_mr_init [0:7];
  logic [2:0]       w_enc_mr;
  logic [17:0]      w_enc_val;
  logic             w_enc_side_b;
  logic             w_enc_rank;
  logic             w_cs0_n;
  logic             w_cs1_n;
  logic [17:0]      w_da;
  logic [1:0]       w_dba;
  logic [1:0]       w_dbg;
  logic             w_par;
  logic             w_pu_last;
  logic             w_accept;

  always_comb begin
    for (int i = 0; i < 7; i++) w_mr_init[i] = MR_INIT[18*i +: 18];
    w_mr_init[7] = '0;
  end

  // Runtime commands come from the latched request, power-up ones from the MR table.
  always_comb begin
    w_enc_mr     = MR_ORDER[r_mr_idx];
    w_enc_val    = w_mr_init[w_enc_mr];
    w_enc_side_b = r_side;
    w_enc_rank   = r_rank;
    if (r_state == ST_REQ_CMD) begin
      w_enc_mr     = r_req_mr;
      w_enc_val    = r_req_data;
      w_enc_side_b = ~r_sides[0];
      w_enc_rank   = r_req_rank;
    end
  end

  ddr4_mrs_encode #(.MIRROR_EN(MIRROR_EN)) u_enc (
    .i_mr     (w_enc_mr),
    .i_val    (w_enc_val),
    .i_side_b (w_enc_side_b),
    .i_rank   (w_enc_rank),
    .o_cs0_n  (w_cs0_n),
    .o_cs1_n  (w_cs1_n),
    .o_da     (w_da),
    .o_dba    (w_dba),
    .o_dbg    (w_dbg),
    .o_par    (w_par)
  );

  assign w_pu_last = r_side & (r_mr_idx == 3'd6) & (r_rank == RANK_LAST);
  assign w_accept  = (r_state == ST_IDLE) & bus.req_valid;

  always_ff @(posedge CK_t) begin
    if (w_accept) begin
      r_req_mr   <= bus.req_mr;
      r_req_rank <= bus.req_rank;
      r_req_data <= bus.req_data;
    end
  end

  always_ff @(posedge CK_t or negedge RST_n) begin
    if (!RST_n) begin
      r_state     <= ST_RST_HOLD;
      r_cnt       <= LD_RST;
      r_mr_idx    <= 3'd0;
      r_side      <= 1'b0;
      r_rank      <= 1'b0;
      r_last      <= 1'b0;
      r_sides     <= 2'b00;
      r_drst_n    <= 1'b0;
      r_dcke      <= 2'b00;
      r_dcs0_n    <= 1'b1;
      r_dcs1_n    <= 1'b1;
      r_da        <= '0;
      r_dba       <= 2'b00;
      r_dbg       <= 2'b00;
      r_dpar      <= 1'b0;
      r_init_done <= 1'b0;
      r_req_ready <= 1'b0;
    end else begin
      // Deselect unless a command state below overrides it.
      r_dcs0_n <= 1'b1;
      r_dcs1_n <= 1'b1;
      r_da     <= '0;
      r_dba    <= 2'b00;
      r_dbg    <= 2'b00;
      r_dpar   <= 1'b0;
      case (r_state)
        ST_RST_HOLD: begin
          if (r_cnt == '0) begin
            r_state  <= ST_CKE_WAIT;
            r_drst_n <= 1'b1;
            r_cnt    <= LD_CKE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_CKE_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_MRS_CMD;
            r_dcke  <= 2'b11;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_MRS_CMD: begin
          r_dcs0_n <= w_cs0_n;
          r_dcs1_n <= w_cs1_n;
          r_da     <= w_da;
          r_dba    <= w_dba;
          r_dbg    <= w_dbg;
          r_dpar   <= w_par;
          r_last   <= w_pu_last;
          r_cnt    <= w_pu_last ? LD_MOD : LD_MRD;
          r_state  <= ST_MRS_GAP;
          if (r_side) begin
            r_side <= 1'b0;
            if (r_mr_idx == 3'd6) begin
              r_mr_idx <= 3'd0;
              r_rank   <= r_rank + 1'b1;
            end else begin
              r_mr_idx <= r_mr_idx + 3'd1;
            end
          end else begin
            r_side <= 1'b1;
          end
        end
        ST_MRS_GAP: begin
          if (r_cnt == '0) begin
            if (r_last) begin
              r_state     <= ST_IDLE;
              r_init_done <= 1'b1;
              r_req_ready <= 1'b1;
            end else begin
              r_state <= ST_MRS_CMD;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_state     <= ST_REQ_CMD;
            r_req_ready <= 1'b0;
            r_sides     <= bus.req_side;
          end
        end
        ST_REQ_CMD: begin
          if (r_sides == 2'b00) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
          end else begin
            r_dcs0_n <= w_cs0_n;
            r_dcs1_n <= w_cs1_n;
            r_da     <= w_da;
            r_dba    <= w_dba;
            r_dbg    <= w_dbg;
            r_dpar   <= w_par;
            r_sides  <= r_sides[0] ? {r_sides[1], 1'b0} : 2'b00;
            r_cnt    <= (r_sides == 2'b11) ? LD_MRD : LD_MOD;
            r_state  <= ST_REQ_GAP;
          end
        end
        ST_REQ_GAP: begin
          if (r_cnt == '0) begin
            if (r_sides != 2'b00) begin
              r_state <= ST_REQ_CMD;
            end else begin
              r_state     <= ST_IDLE;
              r_req_ready <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_RST_HOLD;
      endcase
    end
  end

  assign bus.DRST_n    = r_drst_n;
  assign bus.DCKE      = r_dcke;
  assign bus.DCS0_n    = r_dcs0_n;
  assign bus.DCS1_n    = r_dcs1_n;
  assign bus.DACT_n    = 1'b1;
  assign bus.DA        = r_da;
  assign bus.DBA       = r_dba;
  assign bus.DBG       = r_dbg;
  assign bus.DODT      = 2'b00;
  assign bus.DPAR      = r_dpar;
  assign bus.init_done = r_init_done;
  assign bus.req_ready = r_req_ready;

endmodule

// File: tb/tb_ddr4_rcd_mrs_sequencer.sv
// Directed bench for ddr4_rcd_mrs_sequencer: power-up timing, MRS encoding,
// rank-1 mirroring, runtime requests and asynchronous reset mid-sequence.
module tb_ddr4_rcd_mrs_sequencer;

  localparam int T_RST  = 4;
  localparam int T_CKE  = 6;
  localparam int MRD    = 3;
  localparam int MOD    = 5;
  localparam int NCMD   = 28;
  localparam int FIRST  = T_RST + T_CKE + 1;
  localparam int LASTC  = FIRST + (NCMD - 1) * (MRD + 1);
  localparam int DONE   = LASTC + MOD;
  localparam bit MIRROR = 1'b1;
`ifdef DDR4_RCD_CMD_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [25:0] DESEL = {3'b111, 23'd0};
  localparam int ORDER [0:6] = '{3, 6, 5, 4, 2, 1, 0};

  logic         CK_t = 1'b0;
  logic         RST_n = 1'b0;
  logic [125:0] MR_INIT;
  logic [17:0]  mrv [0:6];
  logic [25:0]  cap [0:DONE];
  logic [25:0]  first_cmd;
  int           n_cmp = 0;
  int           n_err = 0;

  ddr4_rcd_mrs_sequencer_if bus();

  ddr4_rcd_mrs_sequencer #(
    .NUM_RANKS    (2),
    .T_RST_CYC    (T_RST),
    .T_CKE_CYC    (T_CKE),
    .T_MRD        (MRD),
    .T_MOD        (MOD),
    .MC_CA_MIRROR ("ON")
  ) u_dut (
    .CK_t    (CK_t),
    .RST_n   (RST_n),
    .MR_INIT (MR_INIT),
    .bus     (bus)
  );

  always #5 CK_t = ~CK_t;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t exceeded, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] bus_now();
    return {bus.DCS0_n, bus.DCS1_n, bus.DACT_n, bus.DA, bus.DBA, bus.DBG, bus.DPAR};
  endfunction

  function automatic logic [6:0] ctl_now();
    return {bus.DRST_n, bus.DCKE, bus.DODT, bus.init_done, bus.req_ready};
  endfunction

  function automatic logic [6:0] exp_ctl(input bit drst, input bit cke, input bit done);
    return {drst, cke ? 2'b11 : 2'b00, 2'b00, done, done};
  endfunction

  function automatic logic [25:0] exp_enc(input logic [2:0] m, input logic [17:0] v,
                                          input logic sb, input logic rk);
    logic [17:0] a;
    logic [1:0]  ba;
    logic [1:0]  bg;
    logic        p;
    if (!sb) begin
      a = v;            ba = m[1:0];  bg = {1'b0, m[2]};
    end else begin
      a = v ^ 18'h22BF8; ba = ~m[1:0]; bg = {1'b1, ~m[2]};
    end
    a[16:14] = 3'b000;
    if (MIRROR && rk) begin
      a  = {a[17:14], a[11], a[12], a[13], a[10:9], a[7], a[8], a[5], a[6], a[3], a[4], a[2:0]};
      ba = {ba[0], ba[1]};
      bg = {bg[0], bg[1]};
    end
    p = PAR_EN ? ^{1'b1, a, ba, bg} : 1'b0;
    return {rk, ~rk, 1'b1, a, ba, bg, p};
  endfunction

  function automatic logic [25:0] exp_pu(input int i);
    int mr;
    mr = ORDER[(i % 14) / 2];
    return exp_enc(3'(mr), mrv[mr], 1'(i % 2), 1'(i / 14));
  endfunction

  task automatic tick();
    @(posedge CK_t);
    #1;
  endtask

  task automatic run_powerup(input int ncyc);
    logic [25:0] e;
    for (int k = 0; k <= ncyc; k++) begin
      tick();
      e = DESEL;
      if (k >= FIRST && ((k - FIRST) % (MRD + 1)) == 0 && ((k - FIRST) / (MRD + 1)) < NCMD)
        e = exp_pu((k - FIRST) / (MRD + 1));
      cap[k] = bus_now();
      check_val($sformatf("pu_bus@%0d", k), 32'(bus_now()), 32'(e));
      check_val($sformatf("pu_ctl@%0d", k), 32'(ctl_now()),
                32'(exp_ctl(k >= T_RST, k >= T_RST + T_CKE, k >= DONE)));
    end
  endtask

  task automatic run_req(input string tag, input logic [2:0] mr, input logic rk,
                         input logic [1:0] side, input logic [17:0] data,
                         output logic [25:0] first);
    int          w;
    int          rdy_at;
    logic [25:0] e;
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    check_val($sformatf("%s_ready_before", tag), 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_mr    = mr;
    bus.req_rank  = rk;
    bus.req_side  = side;
    bus.req_data  = data;
    tick();
    bus.req_valid = 1'b0;
    check_val($sformatf("%s_ready_drop", tag), 32'(bus.req_ready), 32'd0);
    rdy_at = (side == 2'b00) ? 1 : (side == 2'b11) ? (MRD + 2 + MOD) : (1 + MOD);
    first  = DESEL;
    for (int j = 1; j <= rdy_at; j++) begin
      tick();
      e = DESEL;
      if (side != 2'b00 && j == 1)      e = exp_enc(mr, data, ~side[0], rk);
      if (side == 2'b11 && j == MRD + 2) e = exp_enc(mr, data, 1'b1, rk);
      if (j == 1) first = bus_now();
      check_val($sformatf("%s_bus@+%0d", tag, j), 32'(bus_now()), 32'(e));
      check_val($sformatf("%s_ready@+%0d", tag, j), 32'(bus.req_ready), 32'(j == rdy_at));
    end
  endtask

  initial begin
    mrv[0] = 18'h00A34; mrv[1] = 18'h00101; mrv[2] = 18'h00008; mrv[3] = 18'h00004;
    mrv[4] = 18'h02000; mrv[5] = 18'h00400; mrv[6] = 18'h0481F;
    MR_INIT = {mrv[6], mrv[5], mrv[4], mrv[3], mrv[2], mrv[1], mrv[0]};
    bus.req_valid = 1'b0;
    bus.req_mr    = 3'd0;
    bus.req_rank  = 1'b0;
    bus.req_side  = 2'b00;
    bus.req_data  = 18'd0;

    repeat (3) @(negedge CK_t);
    check_val("rst_bus", 32'(bus_now()), 32'(DESEL));
    check_val("rst_ctl", 32'(ctl_now()), 32'(exp_ctl(1'b0, 1'b0, 1'b0)));
    RST_n = 1'b1;

    // Reset arrives in the gap after the first MRS and must clear everything at once.
    run_powerup(FIRST + 2);
    #2;
    RST_n = 1'b0;
    #1;
    check_val("midrst_bus", 32'(bus_now()), 32'(DESEL));
    check_val("midrst_ctl", 32'(ctl_now()), 32'(exp_ctl(1'b0, 1'b0, 1'b0)));
    repeat (2) @(negedge CK_t);
    RST_n = 1'b1;

    // A request held during power-up must be ignored until IDLE.
    bus.req_valid = 1'b1;
    bus.req_side  = 2'b11;
    bus.req_mr    = 3'd2;
    run_powerup(DONE);
    bus.req_valid = 1'b0;

    check_val("pu_pre_cmd", 32'(cap[FIRST - 1]), 32'(DESEL));
    check_val("pu_mr3_a_r0", 32'(cap[FIRST]), 32'({1'b0, 1'b1, 1'b1, 18'h00004, 2'b11, 2'b00, 1'b0}));
    check_val("pu_mr0_b_r0", 32'(cap[FIRST + 13 * (MRD + 1)]),
              32'({1'b0, 1'b1, 1'b1, 18'h221CC, 2'b11, 2'b11, 1'b0}));
    check_val("pu_mr4_a_r1_mirror", 32'(cap[FIRST + 20 * (MRD + 1)]),
              32'({1'b1, 1'b0, 1'b1, 18'h00800, 2'b00, 2'b10, PAR_EN}));
    check_val("pu_mr2_a_r1_mirror", 32'(cap[FIRST + 22 * (MRD + 1)]),
              32'({1'b1, 1'b0, 1'b1, 18'h00010, 2'b01, 2'b00, PAR_EN}));

    run_req("req_mr1_ab", 3'd1, 1'b0, 2'b11, 18'h00101, first_cmd);
    check_val("req_mr1_a_cmd", 32'(first_cmd), 32'({1'b0, 1'b1, 1'b1, 18'h00101, 2'b01, 2'b00, 1'b0}));
    run_req("req_mr5_b_r1", 3'd5, 1'b1, 2'b10, 18'h12345, first_cmd);
    run_req("req_none", 3'd4, 1'b0, 2'b00, 18'h3FFFF, first_cmd);
    check_val("req_none_cmd", 32'(first_cmd), 32'(DESEL));
    run_req("req_par_da1", 3'd0, 1'b0, 2'b01, 18'h00001, first_cmd);
    check_val("req_par_da1_cmd", 32'(first_cmd), 32'({1'b0, 1'b1, 1'b1, 18'h00001, 2'b00, 2'b00, 1'b0}));
    run_req("req_par_da0", 3'd0, 1'b0, 2'b01, 18'h00000, first_cmd);
    check_val("req_par_da0_cmd", 32'(first_cmd), 32'({1'b0, 1'b1, 1'b1, 18'h00000, 2'b00, 2'b00, PAR_EN}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
